// File: rtl/decode_pkg.sv
// Shared types for the decode stage: instruction classes, RV32I opcodes and
// the opcode-to-class mapping.
package decode_pkg;

    typedef enum logic [3:0] {
        NOP     = 4'd0,
        LOAD    = 4'd1,
        STORE   = 4'd2,
        ALU     = 4'd3,
        UPPER   = 4'd4,
        BRANCH  = 4'd5,
        JUMP    = 4'd6,
        SYSTEM  = 4'd7,
        INVALID = 4'd8
    } i_class_t;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_ALU_I  = 7'h13;
    localparam logic [6:0] OP_ALU_R  = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [6:0] OP_FENCE  = 7'h0F;

    function automatic i_class_t classify(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD:            return LOAD;
            OP_STORE:           return STORE;
            OP_ALU_I, OP_ALU_R: return ALU;
            OP_LUI, OP_AUIPC:   return UPPER;
            OP_BRANCH:          return BRANCH;
            OP_JAL, OP_JALR:    return JUMP;
            OP_SYSTEM:          return SYSTEM;
            OP_FENCE:           return NOP;
            default:            return INVALID;
        endcase
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate extraction: picks the I/S/B/U/J layout from the
// opcode and sign-extends to 32 bits; R-type, fence and unknown opcodes give 0.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instruction[6:0])
            OP_LOAD, OP_ALU_I, OP_JALR, OP_SYSTEM:
                imm = {{20{instruction[31]}}, instruction[31:20]};
            OP_STORE:
                imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            OP_BRANCH:
                imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                       instruction[30:25], instruction[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instruction[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                       instruction[20], instruction[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: registers the decoded fields for execute and raises a
// combinational bubble when the presented instruction consumes the prior load.
module decode
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        jump,
    input  logic [31:0] instruction,
    input  logic [31:0] NPC_in,
    input  logic [3:0]  tag_in,
    output logic        bubble,
    output logic        valid,
    output i_class_t    i_class,
    output logic [2:0]  funct3,
    output logic        alt,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [31:0] NPC_out,
    output logic [3:0]  tag_out
);

    logic [4:0]  last_load_rd_reg;
    logic [6:0]  opcode;
    logic [4:0]  rs1_field;
    logic [4:0]  rs2_field;
    logic [4:0]  rd_field;
    logic [31:0] imm_next;
    i_class_t    class_next;
    logic        reads_rs1;
    logic        reads_rs2;
    logic        hazard;

    assign opcode     = instruction[6:0];
    assign rs1_field  = instruction[19:15];
    assign rs2_field  = instruction[24:20];
    assign rd_field   = instruction[11:7];
    assign class_next = classify(opcode);

    // JAL has no rs1, unlike JALR, so it is excluded by opcode rather than class.
    assign reads_rs1 = !(class_next == UPPER || class_next == NOP || opcode == OP_JAL);
    assign reads_rs2 = (class_next == STORE) || (class_next == BRANCH) || (opcode == OP_ALU_R);

    assign hazard = (last_load_rd_reg != 5'd0) &&
                    ((reads_rs1 && rs1_field == last_load_rd_reg) ||
                     (reads_rs2 && rs2_field == last_load_rd_reg));
    assign bubble = hazard && !jump;

    imm_gen u_imm_gen (
        .instruction (instruction),
        .imm         (imm_next)
    );

    always_ff @(posedge clk) begin
        if (!reset || jump || hazard) begin
            valid            <= 1'b0;
            i_class          <= NOP;
            funct3           <= '0;
            alt              <= 1'b0;
            rs1              <= '0;
            rs2              <= '0;
            rd               <= '0;
            imm              <= '0;
            NPC_out          <= '0;
            tag_out          <= '0;
            last_load_rd_reg <= '0;
        end else begin
            valid            <= 1'b1;
            i_class          <= class_next;
            funct3           <= instruction[14:12];
            alt              <= instruction[30];
            rs1              <= rs1_field;
            rs2              <= rs2_field;
            rd               <= rd_field;
            imm              <= imm_next;
            NPC_out          <= NPC_in;
            tag_out          <= tag_in;
            last_load_rd_reg <= (class_next == LOAD) ? rd_field : 5'd0;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: a field-level reference model checked every cycle
// plus hand-computed expectations for the key vectors.
module tb_decode;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] instruction = 32'h0000_0013;
    logic [31:0] NPC_in = '0;
    logic [3:0]  tag_in = '0;
    logic        bubble;
    logic        valid;
    i_class_t    i_class;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] NPC_out;
    logic [3:0]  tag_out;

    int tests = 0;
    int fails = 0;

    decode dut (
        .clk         (clk),
        .reset       (reset),
        .jump        (jump),
        .instruction (instruction),
        .NPC_in      (NPC_in),
        .tag_in      (tag_in),
        .bubble      (bubble),
        .valid       (valid),
        .i_class     (i_class),
        .funct3      (funct3),
        .alt         (alt),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .imm         (imm),
        .NPC_out     (NPC_out),
        .tag_out     (tag_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic i_class_t m_class(input logic [31:0] w);
        case (w[6:0])
            7'h03: return LOAD;
            7'h23: return STORE;
            7'h13, 7'h33: return ALU;
            7'h37, 7'h17: return UPPER;
            7'h63: return BRANCH;
            7'h6F, 7'h67: return JUMP;
            7'h73: return SYSTEM;
            7'h0F: return NOP;
            default: return INVALID;
        endcase
    endfunction

    // Immediates built by weighted sums of the scattered fields.
    function automatic logic [31:0] m_imm(input logic [31:0] w);
        int v;
        int sgn;
        sgn = w[31] ? -1 : 0;
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: v = sgn * 2048 + int'(w[30:20]);
            7'h23: v = sgn * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]);
            7'h63: v = sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            7'h37, 7'h17: v = int'(w & 32'hFFFF_F000);
            7'h6F: v = sgn * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic bit m_hazard(input logic [31:0] w, input logic [4:0] lld);
        bit uses1;
        bit uses2;
        uses1 = !(w[6:0] inside {7'h37, 7'h17, 7'h0F, 7'h6F});
        uses2 = w[6:0] inside {7'h23, 7'h63, 7'h33};
        return (lld != 0) && ((uses1 && w[19:15] == lld) || (uses2 && w[24:20] == lld));
    endfunction

    bit          m_live = 0;
    bit          m_full = 0;
    logic [4:0]  m_lld = '0;
    logic        m_valid;
    i_class_t    m_cls;
    logic [31:0] m_word;
    logic [31:0] m_npc;
    logic [3:0]  m_tag;

    always @(posedge clk) begin
        if (!reset) begin
            m_live  = 1;
            m_full  = 1;
            m_valid = 0;
            m_cls   = NOP;
            m_word  = '0;
            m_npc   = '0;
            m_tag   = '0;
            m_lld   = '0;
        end else if (m_live) begin
            if (jump || m_hazard(instruction, m_lld)) begin
                m_full  = 0;
                m_valid = 0;
                m_cls   = NOP;
                m_lld   = '0;
            end else begin
                m_full  = 1;
                m_valid = 1;
                m_cls   = m_class(instruction);
                m_word  = instruction;
                m_npc   = NPC_in;
                m_tag   = tag_in;
                m_lld   = (m_cls == LOAD) ? instruction[11:7] : 5'd0;
            end
        end
    end

    // Compare process: inputs change just after posedge, so at negedge the
    // registered outputs and the bubble for the presented word are both settled.
    always @(negedge clk) begin
        if (m_live) begin
            chk("model_bubble", 32'(bubble), 32'(m_hazard(instruction, m_lld) && !jump));
            chk("model_valid", 32'(valid), 32'(m_valid));
            chk("model_class", 32'(i_class), 32'(m_cls));
            if (m_full && m_valid) begin
                chk("model_funct3", 32'(funct3), 32'(m_word[14:12]));
                chk("model_alt", 32'(alt), 32'(m_word[30]));
                chk("model_rs1", 32'(rs1), 32'(m_word[19:15]));
                chk("model_rs2", 32'(rs2), 32'(m_word[24:20]));
                chk("model_rd", 32'(rd), 32'(m_word[11:7]));
                chk("model_imm", imm, m_imm(m_word));
                chk("model_npc", NPC_out, m_npc);
                chk("model_tag", 32'(tag_out), 32'(m_tag));
            end else if (m_full) begin
                chk("model_reset_zero", {funct3, alt, rs1, rs2, rd, tag_out}, 32'd0);
                chk("model_reset_imm", imm | NPC_out, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic [31:0] w, input logic [31:0] npc,
                         input logic j, input logic rst_n);
        @(posedge clk);
        #1;
        instruction = w;
        NPC_in      = npc;
        jump        = j;
        reset       = rst_n;
        @(negedge clk);
    endtask

    localparam logic [31:0] ADDI_X1  = 32'h0050_0093;
    localparam logic [31:0] LW_X2    = 32'h0000_A103;
    localparam logic [31:0] ADD_X3   = 32'h0011_01B3;
    localparam logic [31:0] LW_X0    = 32'h0000_A003;
    localparam logic [31:0] ADD_X0   = 32'h0010_01B3;
    localparam logic [31:0] BEQ_M4   = 32'hFE00_0EE3;
    localparam logic [31:0] LUI_X5   = 32'h1234_52B7;
    localparam logic [31:0] BAD_OP   = 32'h0000_007F;
    localparam logic [31:0] FENCE    = 32'h0000_000F;
    localparam logic [31:0] SW_M8    = 32'hFE51_2C23;
    localparam logic [31:0] JAL_P8   = 32'h0080_00EF;

    initial begin
        tag_in = 4'd0;
        apply(32'h0000_0013, 32'h0, 1'b0, 1'b0);
        apply(32'h0000_0013, 32'h0, 1'b0, 1'b0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_class", 32'(i_class), 32'(NOP));
        chk("reset_bubble", 32'(bubble), 32'd0);

        apply(ADDI_X1, 32'h04, 1'b0, 1'b1);
        apply(LW_X2, 32'h08, 1'b0, 1'b1);
        chk("addi_valid", 32'(valid), 32'd1);
        chk("addi_class", 32'(i_class), 32'(ALU));
        chk("addi_rd", 32'(rd), 32'd1);
        chk("addi_rs1", 32'(rs1), 32'd0);
        chk("addi_imm", imm, 32'd5);
        chk("lw_bubble", 32'(bubble), 32'd0);

        apply(ADD_X3, 32'h0C, 1'b0, 1'b1);
        chk("ld_use_bubble", 32'(bubble), 32'd1);
        chk("lw_class", 32'(i_class), 32'(LOAD));
        apply(ADD_X3, 32'h0C, 1'b0, 1'b1);
        chk("stall_bubble_clear", 32'(bubble), 32'd0);
        chk("stall_valid", 32'(valid), 32'd0);
        chk("stall_class", 32'(i_class), 32'(NOP));
        apply(LW_X0, 32'h10, 1'b0, 1'b1);
        chk("add_valid", 32'(valid), 32'd1);
        chk("add_regs", {rs1, rs2, rd}, {17'd0, 5'd2, 5'd1, 5'd3});
        chk("add_npc", NPC_out, 32'h0C);

        apply(ADD_X0, 32'h14, 1'b0, 1'b1);
        chk("x0_load_no_bubble", 32'(bubble), 32'd0);
        apply(BEQ_M4, 32'h18, 1'b0, 1'b1);
        chk("x0_add_no_bubble", 32'(bubble), 32'd0);
        apply(LUI_X5, 32'h1C, 1'b0, 1'b1);
        chk("beq_class", 32'(i_class), 32'(BRANCH));
        chk("beq_imm", imm, 32'hFFFF_FFFC);
        apply(LW_X2, 32'h20, 1'b0, 1'b1);
        chk("lui_class", 32'(i_class), 32'(UPPER));
        chk("lui_imm", imm, 32'h1234_5000);

        apply(ADD_X3, 32'h24, 1'b1, 1'b1);
        chk("jump_bubble", 32'(bubble), 32'd0);
        tag_in = 4'd1;
        apply(ADD_X3, 32'h40, 1'b0, 1'b1);
        chk("jump_valid", 32'(valid), 32'd0);
        chk("jump_lld_cleared", 32'(bubble), 32'd0);
        apply(LW_X2, 32'h44, 1'b0, 1'b1);
        chk("post_jump_tag", 32'(tag_out), 32'd1);
        chk("post_jump_valid", 32'(valid), 32'd1);

        apply(ADD_X3, 32'h48, 1'b0, 1'b1);
        chk("second_stall", 32'(bubble), 32'd1);
        apply(BAD_OP, 32'h48, 1'b0, 1'b0);
        apply(ADD_X3, 32'h48, 1'b0, 1'b1);
        chk("midstall_reset_valid", 32'(valid), 32'd0);
        chk("midstall_reset_imm", imm, 32'd0);
        chk("midstall_reset_bubble", 32'(bubble), 32'd0);
        apply(BAD_OP, 32'h4C, 1'b0, 1'b1);
        chk("reissue_class", 32'(i_class), 32'(ALU));
        apply(FENCE, 32'h50, 1'b0, 1'b1);
        chk("invalid_class", 32'(i_class), 32'(INVALID));
        chk("invalid_valid", 32'(valid), 32'd1);
        apply(SW_M8, 32'h54, 1'b0, 1'b1);
        chk("fence_imm", imm, 32'd0);
        apply(JAL_P8, 32'h58, 1'b0, 1'b1);
        chk("sw_imm", imm, 32'hFFFF_FFF8);
        apply(FENCE, 32'h5C, 1'b0, 1'b1);
        chk("jal_imm", imm, 32'd8);
        chk("jal_class", 32'(i_class), 32'(JUMP));
        apply(FENCE, 32'h60, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Second pipeline stage. Sits directly downstream of the fetch stage.
- Each cycle it takes the instruction word returned by instruction memory, together with the NPC and tag that fetch produced for it.
- It decodes the RV32I word into an instruction class, register addresses and a sign-extended immediate, and registers these for the execute stage.
- It detects load-use hazards and drives a bubble request that fetch uses as its hold signal (fetch ce = !bubble).

Parameters:
- none

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- jump  in  1  branch taken at retire; flush
- instruction  in  32  word read from memory at fetch i_address
- NPC_in  in  32  PC of instruction, from fetch NPC
- tag_in  in  4  instruction tag, from fetch tag_out
- bubble  out  1  combinational; 1 = fetch must hold this cycle
- valid  out  1  registered outputs hold a real instruction
- i_class  out  i_class_t  decoded class
- funct3  out  3  instruction[14:12]
- alt  out  1  instruction[30] (SUB/SRA select)
- rs1  out  5  source register 1 address
- rs2  out  5  source register 2 address
- rd  out  5  destination register address
- imm  out  32  sign-extended immediate
- NPC_out  out  32  PC passed to execute
- tag_out  out  4  tag passed to execute

Behaviour:
- Single clock, clk; all state updates on its rising edge. Reset is synchronous and active-low on port reset. In reset, all registered outputs are 0, i_class=NOP, valid=0, and the internal last_load_rd is cleared.
- Latency is 1 cycle from instruction to registered outputs. instruction, NPC_in and tag_in are aligned and stay stable while bubble=1, because fetch holds.
- Opcode decode (instruction[6:0]):
  - 0x03 → LOAD
  - 0x23 → STORE
  - 0x13, 0x33 → ALU
  - 0x37, 0x17 → UPPER
  - 0x63 → BRANCH
  - 0x6F, 0x67 → JUMP
  - 0x73 → SYSTEM
  - 0x0F → NOP
  - anything else → INVALID, with valid=1 so retire can trap.
- Immediate format is selected by opcode:
  - I: [31:20] sign-extended
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - R-type and NOP: 0
  - All results are sign-extended from the top bit to 32 bits.
- rs1, rs2 and rd are the raw fields, passed through unmodified.
- Load-use hazard:
  - Condition: hazard = last_load_rd != 0 and the current instruction reads rs1 == last_load_rd, or reads rs2 == last_load_rd. Register reads depend on class: rs1 for all classes except UPPER, NOP and JAL; rs2 for STORE, BRANCH and R-type ALU.
  - bubble = hazard & !jump, combinational.
  - While bubble=1: next cycle valid=0, i_class=NOP, and last_load_rd is cleared. The stalled instruction is re-presented and issues the following cycle.
- last_load_rd update: when a valid instruction issues, last_load_rd = rd if i_class==LOAD, else 0.
- jump has priority over hazard:
  - Next cycle: valid=0, i_class=NOP, last_load_rd=0, bubble forced 0.
  - Instructions arriving with the new tag decode normally afterwards.
- The tag is passed through unchanged. Discarding stale tags is retire's job.
- Reset mid-stall: the state clears, and the next cycle decodes the presented instruction with no hazard.

Decomposition:
- Shared package (e.g. pkg): typedef enum i_class_t {NOP, LOAD, STORE, ALU, UPPER, BRANCH, JUMP, SYSTEM, INVALID}, plus opcode localparams.
- One natural sub-module, imm_gen: combinational, takes instruction and produces imm. Hazard detection and pipeline registers stay in decode.

Test Plan:
- ADDI x1,x0,5 (0x00500093) → next cycle: valid=1, i_class=ALU, rd=1, rs1=0, imm=5, bubble=0.
- LW x2,0(x1) (0x0000A103) followed by ADD x3,x2,x1 (0x001101B3):
  - bubble=1 for exactly 1 cycle while ADD is presented.
  - One valid=0 NOP cycle, then ADD issues with rs1=2, rs2=1, rd=3.
- LW x0,0(x1) followed by ADD x3,x0,x1 → bubble stays 0 throughout.
- BEQ x0,x0,-4 (0xFE000EE3) → i_class=BRANCH, imm=0xFFFFFFFC. LUI x5,0x12345 (0x123452B7) → i_class=UPPER, imm=0x12345000.
- jump=1 in the same cycle as a load-use hazard → bubble=0, next cycle valid=0, and last_load_rd cleared, so the following instruction is not stalled.
- reset low during a stall, and unknown opcode 0x7F → all outputs 0 after the reset edge; later 0x0000007F decodes to i_class=INVALID with valid=1.
